// File: rtl/seletor_velocidade.sv
// seletor_velocidade -- speed command source for the toy's speed display.
//
// Two active-low push buttons step a three-level speed ladder
// (PARADO -> LENTO -> RAPIDO). An active-high emergency stop forces PARADO.
// The 2-bit code {chave_1, chave_0} feeds the speed 7-segment decoder
// directly. A motor PWM follows the selected speed.
//
// Ports:
//   clk         system clock, all state on the rising edge
//   reset_n     asynchronous active-low reset
//   botao_mais  speed-up button, active-low, asynchronous
//   botao_menos speed-down button, active-low, asynchronous
//   parar       emergency stop, active-high, asynchronous
//   chave_0     speed code LSB (registered)
//   chave_1     speed code MSB (registered)
//   pwm_motor   motor PWM (registered)
//   mudando     high while the post-change dwell lockout runs (registered)
module seletor_velocidade #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int DWELL_CYCLES    = 25000000,
   parameter int PWM_PERIOD      = 1000,
   parameter int DUTY_LENTO      = 500
) (
   input  logic clk,
   input  logic reset_n,
   input  logic botao_mais,
   input  logic botao_menos,
   input  logic parar,
   output logic chave_0,
   output logic chave_1,
   output logic pwm_motor,
   output logic mudando
);

   localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int DWW = $clog2(DWELL_CYCLES + 1);
   localparam int PW  = $clog2(PWM_PERIOD + 1);

   localparam logic [DBW-1:0] DEB_LAST   = DBW'(DEBOUNCE_CYCLES - 1);
   localparam logic [DWW-1:0] DWELL_LOAD = DWW'(DWELL_CYCLES);
   localparam logic [PW-1:0]  PWM_LAST   = PW'(PWM_PERIOD - 1);
   localparam logic [PW-1:0]  DUTY_L     = PW'(DUTY_LENTO);
   localparam logic [PW-1:0]  DUTY_R     = PW'(PWM_PERIOD);

   typedef enum logic [1:0] {
      PARADO = 2'b00,
      LENTO  = 2'b01,
      RAPIDO = 2'b10
   } estado_t;

   // Duty in high cycles per period for each speed; RAPIDO equals the
   // period so the comparison below never goes low.
   function automatic logic [PW-1:0] duty_de(input estado_t e);
      case (e)
         LENTO:   duty_de = DUTY_L;
         RAPIDO:  duty_de = DUTY_R;
         default: duty_de = '0;
      endcase
   endfunction

   // ---- Stage: 2-flop synchronizers (reset to the released/idle level)
   logic mais_s1, mais_s2, menos_s1, menos_s2, parar_s1, parar_s2;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mais_s1  <= 1'b1;
         mais_s2  <= 1'b1;
         menos_s1 <= 1'b1;
         menos_s2 <= 1'b1;
         parar_s1 <= 1'b0;
         parar_s2 <= 1'b0;
      end else begin
         mais_s1  <= botao_mais;
         mais_s2  <= mais_s1;
         menos_s1 <= botao_menos;
         menos_s2 <= menos_s1;
         parar_s1 <= parar;
         parar_s2 <= parar_s1;
      end
   end

   // ---- Stage: debounce; a press pulse fires only on the accepted
   //      released->pressed change, so a held button yields one pulse.
   logic           deb_mais, deb_menos;
   logic [DBW-1:0] cnt_mais, cnt_menos;
   logic           pulso_mais, pulso_menos;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         deb_mais   <= 1'b1;
         cnt_mais   <= '0;
         pulso_mais <= 1'b0;
      end else begin
         pulso_mais <= 1'b0;
         if (mais_s2 == deb_mais) begin
            cnt_mais <= '0;
         end else if (cnt_mais == DEB_LAST) begin
            deb_mais   <= mais_s2;
            cnt_mais   <= '0;
            pulso_mais <= ~mais_s2;
         end else begin
            cnt_mais <= cnt_mais + DBW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         deb_menos   <= 1'b1;
         cnt_menos   <= '0;
         pulso_menos <= 1'b0;
      end else begin
         pulso_menos <= 1'b0;
         if (menos_s2 == deb_menos) begin
            cnt_menos <= '0;
         end else if (cnt_menos == DEB_LAST) begin
            deb_menos   <= menos_s2;
            cnt_menos   <= '0;
            pulso_menos <= ~menos_s2;
         end else begin
            cnt_menos <= cnt_menos + DBW'(1);
         end
      end
   end

   // ---- Stage: speed ladder with dwell lockout and emergency stop
   estado_t        estado, prox;
   logic           aceita;
   logic [DWW-1:0] dwell_cnt;

   // Simultaneous up/down pulses cancel; pulses at a ladder end do not
   // count as an accepted change and so do not start a dwell.
   always_comb begin
      prox   = estado;
      aceita = 1'b0;
      if (!parar_s2 && (dwell_cnt == '0) && (pulso_mais ^ pulso_menos)) begin
         if (pulso_mais) begin
            case (estado)
               PARADO:  prox = LENTO;
               LENTO:   prox = RAPIDO;
               default: prox = estado;
            endcase
         end else begin
            case (estado)
               RAPIDO:  prox = LENTO;
               LENTO:   prox = PARADO;
               default: prox = estado;
            endcase
         end
         aceita = (prox != estado);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         estado    <= PARADO;
         dwell_cnt <= '0;
         mudando   <= 1'b0;
      end else if (parar_s2) begin
         estado    <= PARADO;
         dwell_cnt <= '0;
         mudando   <= 1'b0;
      end else if (aceita) begin
         estado    <= prox;
         dwell_cnt <= DWELL_LOAD;
         mudando   <= 1'b1;
      end else if (dwell_cnt != '0) begin
         dwell_cnt <= dwell_cnt - DWW'(1);
         mudando   <= (dwell_cnt != DWW'(1));
      end
   end

   assign chave_1 = estado[1];
   assign chave_0 = estado[0];

   // ---- Stage: PWM; duty reloads only on the wrap so every period is
   //      whole. The output is computed from next-cycle values so it lines
   //      up with the counter it describes.
   logic [PW-1:0] pwm_cnt, duty_ativo, cnt_prox, duty_prox;
   logic          wrap;

   always_comb begin
      wrap      = (pwm_cnt == PWM_LAST);
      cnt_prox  = wrap ? '0 : pwm_cnt + PW'(1);
      duty_prox = wrap ? duty_de(estado) : duty_ativo;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pwm_cnt    <= '0;
         duty_ativo <= '0;
         pwm_motor  <= 1'b0;
      end else begin
         pwm_cnt <= cnt_prox;
         if (parar_s2) begin
            // Stop overrides immediately; the zeroed duty keeps the motor
            // off after release until the next wrap reloads PARADO.
            duty_ativo <= '0;
            pwm_motor  <= 1'b0;
         end else begin
            duty_ativo <= duty_prox;
            pwm_motor  <= (cnt_prox < duty_prox);
         end
      end
   end

endmodule

// File: doc/seletor_velocidade.md
Name: seletor_velocidade

Overview:
- Speed command source for the toy's speed display.
- Turns two push buttons (up/down) and an emergency-stop input into the registered 2-bit speed code chave_1/chave_0. That code is the exact input pair the speed 7-segment decoder consumes.
- Also drives a motor PWM whose duty matches the selected speed.
- Adds debouncing, a one-level-per-step speed ladder, a minimum dwell time between changes, and glitch-free duty updates.

Parameters:
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles required to accept a button level change (10 ms at 50 MHz).
- DWELL_CYCLES, 25000000: lockout after each accepted speed change (0.5 s at 50 MHz); must be >= 1.
- PWM_PERIOD, 1000: PWM period in clocks; must be >= 2.
- DUTY_LENTO, 500: high cycles per period at speed LENTO; must satisfy 0 < DUTY_LENTO < PWM_PERIOD.

Ports:
- clk, input, 1: system clock; all state on the rising edge.
- reset_n, input, 1: asynchronous active-low reset.
- botao_mais, input, 1: speed-up push button, active-low, asynchronous to clk.
- botao_menos, input, 1: speed-down push button, active-low, asynchronous to clk.
- parar, input, 1: emergency stop, active-high, asynchronous to clk.
- chave_0, output, 1: speed code LSB (registered).
- chave_1, output, 1: speed code MSB (registered).
- pwm_motor, output, 1: motor PWM (registered).
- mudando, output, 1: high while dwell lockout is active (registered).

Behaviour:
- Reset (reset_n low, immediate):
  - chave_1/chave_0 = 00, pwm_motor = 0, mudando = 0.
  - All counters = 0.
  - Debounced button levels = released; synchronizer flops = released (1 for buttons, 0 for parar).
- Synchronization: every asynchronous input passes through a 2-flop synchronizer before use.
- Debounce, per button:
  - The counter increments while the synchronized level differs from the debounced level; it clears to 0 on any cycle where they match.
  - When the count reaches DEBOUNCE_CYCLES, the debounced level takes the new value and the counter clears.
  - A 1-cycle press pulse fires on the cycle the debounced level goes to pressed. Releases produce no pulse.
  - Holding a button gives exactly one pulse (no auto-repeat).
- Speed FSM, states and codes (chave_1, chave_0): PARADO = 00, LENTO = 01, RAPIDO = 10. Code 11 is never driven.
- Transitions, evaluated only when parar_sync = 0 and the dwell counter = 0:
  - up pulse alone: PARADO -> LENTO -> RAPIDO; no change at RAPIDO.
  - down pulse alone: RAPIDO -> LENTO -> PARADO; no change at PARADO.
  - up and down pulses in the same cycle: both ignored.
  - Pulses at a ladder end, during dwell, or during parar are discarded, not queued.
- Dwell:
  - On every accepted transition the dwell counter loads DWELL_CYCLES and mudando = 1 from the next cycle.
  - The counter decrements each cycle; mudando = 0 on the cycle it reaches 0.
  - Pulses are accepted again on the cycle after it reaches 0.
- Emergency stop, while parar_sync = 1:
  - The next edge forces PARADO, clears the dwell counter and mudando, and forces pwm_motor = 0.
  - This holds every cycle while parar_sync stays 1 and bypasses dwell.
  - Deasserting parar does not change speed.
- Latency: button edge to code change = 2 (sync) + DEBOUNCE_CYCLES + 1 cycles.
- PWM:
  - The free-running counter runs 0..PWM_PERIOD-1 and wraps to 0.
  - pwm_motor = 1 when counter < duty, where duty = 0 at PARADO, DUTY_LENTO at LENTO, PWM_PERIOD at RAPIDO (constant 1).
  - The active duty register reloads from the current state only on the wrap cycle, so no truncated or extended pulses occur. The parar override is the only exception.
- Reset mid-operation: immediate return to reset values; any in-progress debounce, dwell or PWM period is abandoned.

Test Plan (DEBOUNCE_CYCLES = 4, DWELL_CYCLES = 16, PWM_PERIOD = 10, DUTY_LENTO = 5):
1. Release reset; press botao_mais cleanly (held low) -> code 00 -> 01 exactly 7 cycles after the press edge; mudando high for 16 cycles; from the next wrap pwm_motor runs 5 high / 5 low.
2. botao_mais with bounce (low 2, high 1, low 2, high 1, then steady low) -> only one step 00 -> 01, occurring 7 cycles after the steady low begins; a 3-cycle glitch alone -> no change.
3. Second up press 8 cycles into dwell -> discarded, code stays 01; up press after mudando falls -> 10, pwm_motor constant 1 from the next wrap; a further up press -> stays 10, mudando stays 0.
4. At RAPIDO, assert parar mid-period and during dwell -> pwm_motor 0 and code 00 exactly 3 cycles after assertion; mudando 0; button presses while parar is high ignored; deasserting parar leaves code at 00.
5. Both buttons pressed with identical timing at LENTO -> no change, mudando stays 0; down press at PARADO -> no change.
6. Pulse reset_n low mid-dwell at LENTO with pwm_motor high -> outputs 00/0/0 immediately during reset; after release, the first accepted up press gives 01 with normal 7-cycle latency.
